// File: rtl/bscan_dr_scheduler.sv
// USER DR scan sequencer: byte-write frames feed a FIFO/valid-ready stream,
// RESULT_WIDTH-bit frames read back the solver result, other lengths count as errors.
module bscan_dr_scheduler #(
    parameter int RESULT_WIDTH = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int ERR_WIDTH    = 8
) (
    input  logic                    tck,
    input  logic                    rst_n,
    input  logic                    test_logic_reset,
    input  logic                    ir_is_user,
    input  logic                    capture_dr,
    input  logic                    shift_dr,
    input  logic                    update_dr,
    input  logic                    tdi,
    output logic                    tdo,
    input  logic [RESULT_WIDTH-1:0] result,
    output logic [7:0]              byte_data,
    output logic                    byte_valid,
    input  logic                    byte_ready,
    output logic                    overflow,
    output logic [ERR_WIDTH-1:0]    frame_err_cnt,
    output logic                    readback_done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(RESULT_WIDTH + 2);
    localparam logic [CW-1:0] CNT_BYTE = CW'(8);
    localparam logic [CW-1:0] CNT_RES  = CW'(RESULT_WIDTH);
    localparam logic [CW-1:0] CNT_MAX  = CW'(RESULT_WIDTH + 1);
    localparam logic [PW-1:0] DEPTH_V  = PW'(FIFO_DEPTH);

    typedef enum logic [3:0] {
        PH_IDLE    = 4'b0001,
        PH_CAPTURE = 4'b0010,
        PH_SHIFT   = 4'b0100,
        PH_UPDATE  = 4'b1000
    } phase_t;

    phase_t                  phase;
    logic [RESULT_WIDTH-1:0] tx_sr;
    logic [7:0]              rx_sr;
    logic [CW-1:0]           bit_cnt;
    logic [7:0]              mem [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [PW-1:0]           rd_next;
    logic [PW-1:0]           count;
    logic                    rst;
    logic                    is_update;
    logic                    byte_frame;
    logic                    err_frame;
    logic                    full;
    logic                    pop;
    logic                    push;

    always_comb begin
        phase = PH_IDLE;
        if (ir_is_user) begin
            if (capture_dr)
                phase = PH_CAPTURE;
            else if (shift_dr)
                phase = PH_SHIFT;
            else if (update_dr)
                phase = PH_UPDATE;
        end
    end

    assign rst        = !rst_n || test_logic_reset;
    assign tdo        = tx_sr[0];
    assign is_update  = (phase == PH_UPDATE);
    assign byte_frame = is_update && (bit_cnt == CNT_BYTE);
    assign err_frame  = is_update && (bit_cnt != '0) && (bit_cnt != CNT_BYTE)
                        && (bit_cnt != CNT_RES);
    assign count      = wr_ptr - rd_ptr;
    assign full       = (count == DEPTH_V);
    assign pop        = byte_valid && byte_ready;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push       = byte_frame && (!full || pop);
    assign rd_next    = rd_ptr + PW'(1);

    always_ff @(posedge tck) begin
        if (rst) begin
            tx_sr         <= '0;
            rx_sr         <= '0;
            bit_cnt       <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            byte_data     <= '0;
            byte_valid    <= 1'b0;
            overflow      <= 1'b0;
            frame_err_cnt <= '0;
            readback_done <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            readback_done <= is_update && (bit_cnt == CNT_RES);

            case (phase)
                PH_CAPTURE: begin
                    tx_sr   <= result;
                    rx_sr   <= '0;
                    bit_cnt <= '0;
                end
                PH_SHIFT: begin
                    tx_sr <= {tdi, tx_sr[RESULT_WIDTH-1:1]};
                    rx_sr <= {tdi, rx_sr[7:1]};
                    if (bit_cnt != CNT_MAX)
                        bit_cnt <= bit_cnt + CW'(1);
                end
                default: ;
            endcase

            if (err_frame && (frame_err_cnt != '1))
                frame_err_cnt <= frame_err_cnt + ERR_WIDTH'(1);

            if (push) begin
                mem[wr_ptr[AW-1:0]] <= rx_sr;
                wr_ptr              <= wr_ptr + PW'(1);
            end
            if (byte_frame && !push)
                overflow <= 1'b1;

            // Head register: reload from the next slot on pop, or fetch when idle.
            if (pop) begin
                rd_ptr     <= rd_next;
                byte_valid <= (wr_ptr != rd_next);
                byte_data  <= mem[rd_next[AW-1:0]];
            end else if (!byte_valid) begin
                byte_valid <= (wr_ptr != rd_ptr);
                byte_data  <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

endmodule

// File: tb/tb_bscan_dr_scheduler.sv
// Directed bench for bscan_dr_scheduler: table of scans plus hand-written
// overflow, saturation and mid-scan reset sequences.
module tb_bscan_dr_scheduler;

    logic        tck = 1'b0;
    logic        rst_n = 1'b1;
    logic        test_logic_reset = 1'b1;
    logic        ir_is_user = 1'b0;
    logic        capture_dr = 1'b0;
    logic        shift_dr = 1'b0;
    logic        update_dr = 1'b0;
    logic        tdi = 1'b0;
    logic        tdo;
    logic [15:0] result = '0;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready = 1'b1;
    logic        overflow;
    logic [7:0]  frame_err_cnt;
    logic        readback_done;

    int tests = 0;
    int fails = 0;

    bscan_dr_scheduler #(.RESULT_WIDTH(16), .FIFO_DEPTH(8), .ERR_WIDTH(8)) dut (
        .tck(tck), .rst_n(rst_n), .test_logic_reset(test_logic_reset),
        .ir_is_user(ir_is_user), .capture_dr(capture_dr), .shift_dr(shift_dr),
        .update_dr(update_dr), .tdi(tdi), .tdo(tdo), .result(result),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .overflow(overflow), .frame_err_cnt(frame_err_cnt), .readback_done(readback_done)
    );

    always #5 tck = ~tck;

    typedef struct {
        int          len;
        logic [31:0] din;
        logic [15:0] res;
        logic        ir;
        logic        exp_valid;
        logic [7:0]  exp_byte;
        logic        exp_done;
        logic [7:0]  exp_err;
    } vec_t;

    vec_t vecs[15];

    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Full capture/shift/update sequence; tdo is sampled before each shift edge.
    task automatic scan(input int n, input logic [31:0] din, input logic ir,
                        output logic [31:0] got);
        got = '0;
        ir_is_user = ir;
        capture_dr = 1'b1;
        tick();
        capture_dr = 1'b0;
        shift_dr   = 1'b1;
        for (int i = 0; i < n; i++) begin
            got[i] = tdo;
            tdi    = din[i];
            tick();
        end
        shift_dr  = 1'b0;
        update_dr = 1'b1;
        tick();
        update_dr = 1'b0;
        tdi       = 1'b0;
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] exp_tdo;
        logic [31:0] mask;
        logic [7:0]  drained[$];
        logic [7:0]  exp_e;

        vecs[0]  = '{8,  32'h4C,    16'h1234, 1'b1, 1'b1, 8'h4C, 1'b0, 8'd0};
        vecs[1]  = '{8,  32'h36,    16'hBEEF, 1'b1, 1'b1, 8'h36, 1'b0, 8'd0};
        vecs[2]  = '{8,  32'h38,    16'h0001, 1'b1, 1'b1, 8'h38, 1'b0, 8'd0};
        vecs[3]  = '{8,  32'h0A,    16'h8000, 1'b1, 1'b1, 8'h0A, 1'b0, 8'd0};
        vecs[4]  = '{16, 32'h0,     16'h0403, 1'b1, 1'b0, 8'h00, 1'b1, 8'd0};
        vecs[5]  = '{16, 32'hFFFF,  16'hA5C3, 1'b1, 1'b0, 8'h00, 1'b1, 8'd0};
        vecs[6]  = '{0,  32'h0,     16'h5A5A, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0};
        vecs[7]  = '{5,  32'h15,    16'h00F0, 1'b1, 1'b0, 8'h00, 1'b0, 8'd1};
        vecs[8]  = '{12, 32'hABC,   16'h0F0F, 1'b1, 1'b0, 8'h00, 1'b0, 8'd2};
        vecs[9]  = '{9,  32'h1FF,   16'h3333, 1'b1, 1'b0, 8'h00, 1'b0, 8'd3};
        vecs[10] = '{17, 32'h10000, 16'hC001, 1'b1, 1'b0, 8'h00, 1'b0, 8'd4};
        vecs[11] = '{20, 32'hF0000, 16'h7777, 1'b1, 1'b0, 8'h00, 1'b0, 8'd5};
        vecs[12] = '{15, 32'h7FFF,  16'h1111, 1'b1, 1'b0, 8'h00, 1'b0, 8'd6};
        vecs[13] = '{7,  32'h55,    16'h2222, 1'b1, 1'b0, 8'h00, 1'b0, 8'd7};
        vecs[14] = '{8,  32'h99,    16'h4444, 1'b0, 1'b0, 8'h00, 1'b0, 8'd7};

        // Reset through test_logic_reset
        for (int i = 0; i < 42; i++) tick();
        test_logic_reset = 1'b0;
        tick();
        check("reset_valid", {31'b0, byte_valid}, 32'd0);
        check("reset_tdo", {31'b0, tdo}, 32'd0);
        check("reset_err", {24'b0, frame_err_cnt}, 32'd0);
        check("reset_ovf", {31'b0, overflow}, 32'd0);
        check("reset_done", {31'b0, readback_done}, 32'd0);

        // Table of scans with byte_ready=1
        for (int v = 0; v < 15; v++) begin
            result = vecs[v].res;
            scan(vecs[v].len, vecs[v].din, vecs[v].ir, got);
            if (vecs[v].ir) begin
                exp_tdo = {vecs[v].din[15:0], vecs[v].res};
                mask    = (vecs[v].len >= 32) ? 32'hFFFF_FFFF : ((32'd1 << vecs[v].len) - 32'd1);
                check($sformatf("v%0d_tdo", v), got & mask, exp_tdo & mask);
            end
            check($sformatf("v%0d_done", v), {31'b0, readback_done}, {31'b0, vecs[v].exp_done});
            check($sformatf("v%0d_latency", v), {31'b0, byte_valid}, 32'd0);
            check($sformatf("v%0d_err", v), {24'b0, frame_err_cnt}, {24'b0, vecs[v].exp_err});
            tick();
            check($sformatf("v%0d_valid", v), {31'b0, byte_valid}, {31'b0, vecs[v].exp_valid});
            if (vecs[v].exp_valid)
                check($sformatf("v%0d_byte", v), {24'b0, byte_data}, {24'b0, vecs[v].exp_byte});
            check($sformatf("v%0d_done_pulse", v), {31'b0, readback_done}, 32'd0);
            tick();
            check($sformatf("v%0d_popped", v), {31'b0, byte_valid}, 32'd0);
        end
        check("no_ovf_yet", {31'b0, overflow}, 32'd0);

        // Overflow: nine byte frames into an 8-entry FIFO with no consumer
        byte_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            scan(8, 32'h10 + i, 1'b1, got);
            if (i == 7) begin
                tick();
                check("full_no_ovf", {31'b0, overflow}, 32'd0);
            end
        end
        check("ovf_set", {31'b0, overflow}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_valid", {31'b0, byte_valid}, 32'd1);
            check("hold_data", {24'b0, byte_data}, 32'h10);
        end
        byte_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (byte_valid) drained.push_back(byte_data);
            tick();
        end
        check("drain_count", drained.size(), 32'd8);
        for (int i = 0; i < drained.size() && i < 8; i++)
            check($sformatf("drain_%0d", i), {24'b0, drained[i]}, 32'h10 + i);
        check("ovf_sticky", {31'b0, overflow}, 32'd1);

        // Error counter saturation with 3-bit scans (starts at 7)
        for (int k = 1; k <= 255; k++) begin
            scan(3, 32'h5, 1'b1, got);
            exp_e = (7 + k > 255) ? 8'hFF : 8'(7 + k);
            if (k >= 246)
                check($sformatf("sat_%0d", k), {24'b0, frame_err_cnt}, {24'b0, exp_e});
        end

        // Mid-scan reset after the 4th shift of a byte frame
        byte_ready = 1'b0;
        scan(8, 32'h55, 1'b1, got);
        tick();
        check("pre_rst_valid", {31'b0, byte_valid}, 32'd1);
        capture_dr = 1'b1;
        tick();
        capture_dr = 1'b0;
        shift_dr   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tdi = 1'b1;
            tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        shift_dr  = 1'b0;
        update_dr = 1'b1;
        tick();
        update_dr = 1'b0;
        tdi       = 1'b0;
        tick();
        check("rst_valid", {31'b0, byte_valid}, 32'd0);
        check("rst_ovf", {31'b0, overflow}, 32'd0);
        check("rst_err", {24'b0, frame_err_cnt}, 32'd0);
        check("rst_tdo", {31'b0, tdo}, 32'd0);
        byte_ready = 1'b1;
        scan(8, 32'hA7, 1'b1, got);
        check("post_rst_latency", {31'b0, byte_valid}, 32'd0);
        tick();
        check("post_rst_valid", {31'b0, byte_valid}, 32'd1);
        check("post_rst_byte", {24'b0, byte_data}, 32'hA7);
        tick();
        check("post_rst_pop", {31'b0, byte_valid}, 32'd0);
        check("post_rst_err", {24'b0, frame_err_cnt}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
